// File: rtl/pbvi_pkg.sv
// Shared types and default constants for the PBVI backup-selection stage.
package pbvi_pkg;

  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned N_STATES_DEF = 2;

  typedef logic [N_STATES_DEF-1:0][DW_DEF-1:0] belief_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/pbvi_dot.sv
// Combinational unsigned dot product of two N_STATES-long vectors, at full accumulator width VW.
module pbvi_dot #(
  parameter int unsigned N_STATES = 2,
  parameter int unsigned DW       = 16,
  parameter int unsigned VW       = 33
) (
  input  logic [N_STATES-1:0][DW-1:0] i_a,
  input  logic [N_STATES-1:0][DW-1:0] i_b,
  output logic [VW-1:0]               o_dot
);

  logic [VW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int s = 0; s < N_STATES; s++) begin
      w_acc = w_acc + VW'(i_a[s]) * VW'(i_b[s]);
    end
  end

  assign o_dot = w_acc;

endmodule

// File: rtl/pbvi_argmax_backup.sv
// PBVI backup selection: one action per cycle, per-point running argmax of belief.gamma.
// Optional PBVI_ARGMAX_VALUE_EN exposes the winning dot-product value on o_max_value.
module pbvi_argmax_backup
  import pbvi_pkg::*;
#(
  parameter int unsigned N_POINTS  = 16,
  parameter int unsigned N_STATES  = N_STATES_DEF,
  parameter int unsigned N_ACTIONS = 3,
  parameter int unsigned DW        = DW_DEF,
  localparam int unsigned AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1,
  localparam int unsigned VW = 2 * DW + ((N_STATES > 2) ? $clog2(N_STATES) : 1)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              i_start,
  input  logic [N_ACTIONS-1:0][N_POINTS-1:0][N_STATES-1:0][DW-1:0] i_gamma_ab,
  input  logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0]         i_belief,
  output logic                                              o_busy,
  output logic                                              o_done,
  output logic [N_POINTS-1:0][AW-1:0]                       o_point_action,
  output logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0]         o_alpha
`ifdef PBVI_ARGMAX_VALUE_EN
  ,
  output logic [N_POINTS-1:0][VW-1:0]                       o_max_value
`endif
);

  state_e r_state, w_state_d;
  logic [AW-1:0] r_act_cnt, w_act_cnt_d;
  logic          w_last;

  logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0] w_gamma_sel;
  logic [N_POINTS-1:0][VW-1:0]               w_val;
  logic [N_POINTS-1:0][VW-1:0]               r_max_val;
  logic [N_POINTS-1:0][AW-1:0]               r_point_action;
  logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0] r_alpha;

  assign w_last = (r_act_cnt == AW'(N_ACTIONS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_act_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_act_cnt <= w_act_cnt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_act_cnt_d = r_act_cnt;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_d = EVAL;
      end
      EVAL: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_state_d   = DONE;
          w_act_cnt_d = '0;
        end else begin
          w_act_cnt_d = r_act_cnt + AW'(1);
        end
      end
      DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Constant-index mux keeps out-of-range act_cnt codes harmless for non-power-of-2 N_ACTIONS.
  always_comb begin
    w_gamma_sel = i_gamma_ab[0];
    for (int k = 1; k < N_ACTIONS; k++) begin
      if (r_act_cnt == AW'(k)) w_gamma_sel = i_gamma_ab[k];
    end
  end

  for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_dot
    pbvi_dot #(
      .N_STATES(N_STATES),
      .DW      (DW),
      .VW      (VW)
    ) u_dot (
      .i_a  (i_belief[gi]),
      .i_b  (w_gamma_sel[gi]),
      .o_dot(w_val[gi])
    );
  end

  // First action loads unconditionally; later ones must strictly win so ties keep the lower index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_val      <= '0;
      r_point_action <= '0;
      r_alpha        <= '0;
    end else if (r_state == EVAL) begin
      for (int i = 0; i < N_POINTS; i++) begin
        if ((r_act_cnt == '0) || (w_val[i] > r_max_val[i])) begin
          r_max_val[i]      <= w_val[i];
          r_point_action[i] <= r_act_cnt;
          r_alpha[i]        <= w_gamma_sel[i];
        end
      end
    end
  end

  assign o_point_action = r_point_action;
  assign o_alpha        = r_alpha;
`ifdef PBVI_ARGMAX_VALUE_EN
  assign o_max_value    = r_max_val;
`endif

endmodule

// File: tb/tb_pbvi_argmax_backup.sv
// Self-checking bench for pbvi_argmax_backup: vector table, random passes against a reference
// model, start-while-busy, mid-pass reset, and a single-action build.
module tb_pbvi_argmax_backup;

  localparam int NP  = 16;
  localparam int NS  = 2;
  localparam int NA  = 3;
  localparam int DW  = 16;
  localparam int NP1 = 4;
  localparam int VW  = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                                 start = 1'b0;
  logic [NA-1:0][NP-1:0][NS-1:0][DW-1:0] gamma;
  logic [NP-1:0][NS-1:0][DW-1:0]         belief;
  logic                                 busy, done;
  logic [NP-1:0][1:0]                   pact;
  logic [NP-1:0][NS-1:0][DW-1:0]         alpha;

  logic                                 start1 = 1'b0;
  logic [0:0][NP1-1:0][NS-1:0][DW-1:0]   gamma1;
  logic [NP1-1:0][NS-1:0][DW-1:0]        belief1;
  logic                                 busy1, done1;
  logic [NP1-1:0][0:0]                  pact1;
  logic [NP1-1:0][NS-1:0][DW-1:0]        alpha1;
`ifdef PBVI_ARGMAX_VALUE_EN
  logic [NP-1:0][VW-1:0]                maxv;
  logic [NP1-1:0][VW-1:0]               maxv1;
  logic [NP-1:0][VW-1:0]                maxv_s;
`endif

  pbvi_argmax_backup dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_gamma_ab    (gamma),
    .i_belief      (belief),
    .o_busy        (busy),
    .o_done        (done),
    .o_point_action(pact),
    .o_alpha       (alpha)
`ifdef PBVI_ARGMAX_VALUE_EN
    ,
    .o_max_value   (maxv)
`endif
  );

  pbvi_argmax_backup #(
    .N_POINTS (NP1),
    .N_ACTIONS(1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start1),
    .i_gamma_ab    (gamma1),
    .i_belief      (belief1),
    .o_busy        (busy1),
    .o_done        (done1),
    .o_point_action(pact1),
    .o_alpha       (alpha1)
`ifdef PBVI_ARGMAX_VALUE_EN
    ,
    .o_max_value   (maxv1)
`endif
  );

  int total = 0;
  int bad = 0;

  int                          exp_act[NP];
  logic [NS-1:0][DW-1:0]       exp_alpha[NP];
  longint unsigned             exp_val[NP];
  logic [NP-1:0][1:0]          act_s;
  logic [NP-1:0][NS-1:0][DW-1:0] alp_s;

  typedef struct {
    logic [NS-1:0][DW-1:0]         b;
    logic [NA-1:0][NS-1:0][DW-1:0] g;
    int                            act;
    logic [NS-1:0][DW-1:0]         alp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS-1:0][DW-1:0] v2(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
    logic [NS-1:0][DW-1:0] r;
    r[0] = s0;
    r[1] = s1;
    return r;
  endfunction

  function automatic logic [NA-1:0][NS-1:0][DW-1:0] g3(input logic [NS-1:0][DW-1:0] a0,
                                                      input logic [NS-1:0][DW-1:0] a1,
                                                      input logic [NS-1:0][DW-1:0] a2);
    logic [NA-1:0][NS-1:0][DW-1:0] r;
    r[0] = a0;
    r[1] = a1;
    r[2] = a2;
    return r;
  endfunction

  // Reference: all action values, then the lowest action index attaining the maximum.
  function automatic void model();
    for (int i = 0; i < NP; i++) begin
      longint unsigned v[NA];
      longint unsigned mx;
      int w;
      for (int k = 0; k < NA; k++) begin
        v[k] = 0;
        for (int s = 0; s < NS; s++) v[k] += 64'(belief[i][s]) * 64'(gamma[k][i][s]);
      end
      mx = 0;
      for (int k = 0; k < NA; k++) if (v[k] > mx) mx = v[k];
      w = -1;
      for (int k = 0; k < NA; k++) if (w < 0 && v[k] == mx) w = k;
      exp_act[i]   = w;
      exp_alpha[i] = gamma[w][i];
      exp_val[i]   = mx;
    end
  endfunction

  task automatic randomize_inputs(input int mx);
    for (int i = 0; i < NP; i++)
      for (int s = 0; s < NS; s++) begin
        belief[i][s] = 16'($urandom_range(0, mx));
        for (int k = 0; k < NA; k++) gamma[k][i][s] = 16'($urandom_range(0, mx));
      end
  endtask

  task automatic run_pass(input string tag);
    int dcyc = -1;
    int npulse = 0;
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'(c <= NA + 1));
      if (done) begin
        npulse++;
        if (dcyc < 0) begin
          dcyc  = c;
          act_s = pact;
          alp_s = alpha;
`ifdef PBVI_ARGMAX_VALUE_EN
          maxv_s = maxv;
`endif
        end
      end
      tick();
    end
    chk({tag, " done cycle"}, 64'(dcyc), 64'(NA + 1));
    chk({tag, " done pulses"}, 64'(npulse), 64'(1));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s p%0d action", tag, i), 64'(act_s[i]), 64'(exp_act[i]));
      chk($sformatf("%s p%0d alpha", tag, i), 64'(alp_s[i]), 64'(exp_alpha[i]));
`ifdef PBVI_ARGMAX_VALUE_EN
      chk($sformatf("%s p%0d maxval", tag, i), 64'(maxv_s[i]), exp_val[i]);
`endif
    end
    chk({tag, " hold action"}, 64'(pact[0]), 64'(exp_act[0]));
    chk({tag, " hold alpha"}, 64'(alpha[0]), 64'(exp_alpha[0]));
  endtask

  initial begin
    int dcyc;
    int npulse;
    int d1, d2;

    tbl[0] = '{b: v2(16'd3, 16'd1), g: g3(v2(16'd2, 16'd2), v2(16'd1, 16'd5), v2(16'd4, 16'd0)),
               act: 2, alp: v2(16'd4, 16'd0)};
    tbl[1] = '{b: v2(16'd1, 16'd1), g: g3(v2(16'd5, 16'd5), v2(16'd10, 16'd0), v2(16'd0, 16'd10)),
               act: 0, alp: v2(16'd5, 16'd5)};
    tbl[2] = '{b: v2(16'hFFFF, 16'hFFFF),
               g: g3(v2(16'd0, 16'd0), v2(16'd0, 16'd0), v2(16'hFFFF, 16'hFFFF)),
               act: 2, alp: v2(16'hFFFF, 16'hFFFF)};
    tbl[3] = '{b: v2(16'd1, 16'd0), g: g3(v2(16'd7, 16'd0), v2(16'd9, 16'd1), v2(16'd3, 16'd99)),
               act: 1, alp: v2(16'd9, 16'd1)};
    tbl[4] = '{b: v2(16'd0, 16'd0), g: g3(v2(16'd6, 16'd6), v2(16'd8, 16'd1), v2(16'd2, 16'd2)),
               act: 0, alp: v2(16'd6, 16'd6)};
    tbl[5] = '{b: v2(16'd2, 16'd1), g: g3(v2(16'd1, 16'd1), v2(16'd0, 16'd5), v2(16'd2, 16'd1)),
               act: 1, alp: v2(16'd0, 16'd5)};

    randomize_inputs(65535);
    for (int i = 0; i < NP1; i++)
      for (int s = 0; s < NS; s++) begin
        belief1[i][s]   = 16'($urandom);
        gamma1[0][i][s] = 16'($urandom);
      end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset action", 64'(pact), 64'(0));
    chk("reset alpha0", 64'(alpha[0]), 64'(0));
    chk("reset alpha15", 64'(alpha[15]), 64'(0));
    rst_n = 1'b1;
    tick();

    // Vector table on point 0; other points random and checked by the model
    for (int t = 0; t < 6; t++) begin
      randomize_inputs(15);
      belief[0] = tbl[t].b;
      for (int k = 0; k < NA; k++) gamma[k][0] = tbl[t].g[k];
      run_pass($sformatf("vec%0d", t));
      chk($sformatf("vec%0d tbl action", t), 64'(act_s[0]), 64'(tbl[t].act));
      chk($sformatf("vec%0d tbl alpha", t), 64'(alp_s[0]), 64'(tbl[t].alp));
`ifdef PBVI_ARGMAX_VALUE_EN
      if (t == 2) chk("vec2 wide value", 64'(maxv_s[0]), 64'h1_FFFC_0002);
`endif
    end

    // Random passes; small ranges provoke ties
    for (int r = 0; r < 16; r++) begin
      randomize_inputs((r % 2 == 0) ? 3 : 65535);
      run_pass($sformatf("rnd%0d", r));
    end

    // Start pulses in cycles 2, 4 are ignored; start in cycle 5 begins a new pass
    randomize_inputs(65535);
    model();
    d1 = -1;
    d2 = -1;
    npulse = 0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0 || c == 2 || c == 4 || c == 5);
      if (c >= 1) begin
        chk($sformatf("restart busy c%0d", c), 64'(busy),
            64'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
        if (done) begin
          npulse++;
          if (d1 < 0) d1 = c;
          else if (d2 < 0) d2 = c;
        end
      end
      tick();
    end
    start = 1'b0;
    chk("restart pulses", 64'(npulse), 64'(2));
    chk("restart first done", 64'(d1), 64'(4));
    chk("restart second done", 64'(d2), 64'(9));
    chk("restart p3 action", 64'(pact[3]), 64'(exp_act[3]));

    // Reset asserted in cycle 2 of a pass
    randomize_inputs(65535);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("midrst busy before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("midrst p%0d action", i), 64'(pact[i]), 64'(0));
      chk($sformatf("midrst p%0d alpha", i), 64'(alpha[i]), 64'(0));
    end
    #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 3; c <= 10; c++) begin
      if (done || busy) npulse++;
      tick();
    end
    chk("midrst no activity", 64'(npulse), 64'(0));
    run_pass("postrst");

    // Single-action build
    dcyc = -1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("na1 busy c%0d", c), 64'(busy1), 64'(c <= 2));
      if (done1 && dcyc < 0) begin
        dcyc = c;
        for (int i = 0; i < NP1; i++) begin
          longint unsigned dv;
          dv = 64'(belief1[i][0]) * 64'(gamma1[0][i][0]) + 64'(belief1[i][1]) * 64'(gamma1[0][i][1]);
          chk($sformatf("na1 p%0d action", i), 64'(pact1[i]), 64'(0));
          chk($sformatf("na1 p%0d alpha", i), 64'(alpha1[i]), 64'(gamma1[0][i]));
`ifdef PBVI_ARGMAX_VALUE_EN
          chk($sformatf("na1 p%0d maxval", i), 64'(maxv1[i]), dv);
`else
          if (dv > 64'h1_FFFC_0002) chk("na1 dot range", dv, 64'h1_FFFC_0002);
`endif
        end
      end
      tick();
    end
    chk("na1 done cycle", 64'(dcyc), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pbvi_argmax_backup.md
Name: pbvi_argmax_backup

Overview:
Parametrised PBVI backup-selection stage. For each belief point it evaluates belief·gamma for every action, one action per cycle, across all points in parallel. It keeps the per-point maximum and returns the winning alpha vector and its action index. It sits after gamma-action-belief generation and raises done to hand the results to the value-iteration loop controller.

Parameters:
N_POINTS, 16, number of belief points processed in parallel
N_STATES, 2, belief/alpha vector length
N_ACTIONS, 3, number of candidate actions (>=1)
DW, 16, unsigned width of belief and gamma elements
AW, $clog2(N_ACTIONS) min 1, action index width (localparam)
VW, 2*DW+$clog2(N_STATES) min 2*DW+1, dot-product accumulator width (localparam)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a backup pass
gamma_ab  input  [N_ACTIONS][N_POINTS][N_STATES]xDW  candidate alpha vectors per action/point
belief  input  [N_POINTS][N_STATES]xDW  belief points
busy  output  1  high from the cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse; results valid
point_action  output  [N_POINTS]xAW  winning action per point
alpha  output  [N_POINTS][N_STATES]xDW  winning alpha vector per point

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE, act_cnt=0, busy=0, done=0, point_action all 0, alpha all 0, internal max_val all 0.
- FSM: IDLE -> EVAL on start. EVAL holds for N_ACTIONS cycles, with act_cnt running 0..N_ACTIONS-1. EVAL -> DONE when act_cnt==N_ACTIONS-1. DONE -> IDLE unconditionally.
- EVAL cycle k computes val[i] = sum over s of belief[i][s]*gamma_ab[k][i][s], unsigned, at full width VW. No truncation and no overflow is possible.
- When act_cnt==0, the block loads unconditionally: max_val[i]=val[i], alpha[i]=gamma_ab[0][i], point_action[i]=0.
- When act_cnt>0, the block updates only if val[i] > max_val[i] (strict). Ties keep the lower action index.
- All registers update at the end of the EVAL cycle. Intermediate winners are visible on the outputs during EVAL; only DONE guarantees final values.
- Latency: start sampled at edge 0; done high in cycle N_ACTIONS+1; busy high in cycles 1..N_ACTIONS+1.
- After DONE, outputs hold their values until the next accepted start's first EVAL cycle.
- start while busy is ignored (no restart, no queueing). start in the DONE cycle is also ignored.
- gamma_ab and belief must be stable from the start cycle through the last EVAL cycle. The block does not capture them.
- N_ACTIONS==1: a single EVAL cycle, then DONE; point_action is 0.
- Reset asserted mid-pass: immediate return to IDLE with all outputs at reset values; no done pulse.

Optional Feature:
PBVI_ARGMAX_VALUE_EN
- Defined: adds output port max_value [N_POINTS]xVW. It carries the registered max_val, with the same validity and hold rules as alpha, and resets to 0.
- Undefined: the port is absent. max_val stays internal, with identical selection behaviour.

Decomposition:
- Shared package pbvi_pkg: typedef belief_vec_t (N_STATES x DW), state_e enum {IDLE, EVAL, DONE}, and default-constant localparams for DW/N_STATES.
- One natural sub-module: pbvi_dot, a combinational N_STATES-wide unsigned dot product of width VW.
  - The top level instantiates it N_POINTS times via generate, with gamma muxed by act_cnt.

Test Plan:
- Defaults; point 0 belief={3,1}; gamma action0={2,2}, a1={1,5}, a2={4,0}. Values are 8, 8, 12 -> point_action[0]=2, alpha[0]={4,0}; done in cycle 4; busy cycles 1-3 plus 4.
- Tie: belief={1,1}; gammas {5,5}, {10,0}, {0,10}. All values are 10 -> point_action=0, alpha={5,5}.
- Max operands: belief=gamma=16'hFFFF for all elements, a2 only. Value 0x1_FFFC_0002 must exceed a0=a1=0, so action=2. This checks VW has no overflow.
- start pulsed again in cycles 2 and 4 of a pass -> exactly one done pulse at cycle 4 and no restart. A new start in cycle 5 begins a fresh pass.
- rst_n low in cycle 2 -> busy/done/outputs go 0 asynchronously; no done pulse follows; the next start runs normally.
- N_ACTIONS=1, N_POINTS=4 build: done in cycle 2, all point_action=0, alpha=gamma_ab[0]. With PBVI_ARGMAX_VALUE_EN defined, max_value equals the computed dot products.
